// File: rtl/data_mem_mmio.sv
// Data-side memory for the single-cycle RV32 core: word RAM plus LED and
// compare-timer registers, combinational read, edge-triggered writes.
module data_mem_mmio #(
  parameter int unsigned DEPTH_WORDS = 64,
  parameter int unsigned LED_WIDTH   = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 mem_write,
  input  logic [31:0]          addr,
  input  logic [31:0]          wdata,
  output logic [31:0]          rdata,
  output logic [LED_WIDTH-1:0] leds,
  output logic                 timer_irq,
  output logic                 misaligned
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  localparam logic [31:0] LED_ADDR    = 32'h0000_1000;
  localparam logic [31:0] TCOUNT_ADDR = 32'h0000_1004;
  localparam logic [31:0] TCMP_ADDR   = 32'h0000_1008;
  localparam logic [31:0] TCTRL_ADDR  = 32'h0000_100C;

  logic [31:0]   mem [DEPTH_WORDS];
  logic [AW-1:0] idx;

  logic [31:0] count_q;
  logic [31:0] cmp_q;
  logic        en_q;
  logic        autoreload_q;
  logic        irq_en_q;
  logic        flag_q;

  logic ram_hit, led_hit, count_hit, cmp_hit, ctrl_hit;
  logic we;
  logic match;

  // Address decode; the low two bits only gate alignment
  always_comb begin
    misaligned = (addr[1:0] != 2'b00);
    idx        = addr[AW+1:2];
    ram_hit    = (addr[31:AW+2] == '0);
    led_hit    = (addr[31:2] == LED_ADDR[31:2]);
    count_hit  = (addr[31:2] == TCOUNT_ADDR[31:2]);
    cmp_hit    = (addr[31:2] == TCMP_ADDR[31:2]);
    ctrl_hit   = (addr[31:2] == TCTRL_ADDR[31:2]);
    we         = mem_write & ~misaligned;
    match      = en_q & (count_q == cmp_q);
  end

  // Load data mux; misaligned or unmapped accesses read zero
  always_comb begin
    rdata = '0;
    if (!misaligned) begin
      if (ram_hit)        rdata = mem[idx];
      else if (led_hit)   rdata = 32'(leds);
      else if (count_hit) rdata = count_q;
      else if (cmp_hit)   rdata = cmp_q;
      else if (ctrl_hit)  rdata = {28'd0, flag_q, irq_en_q, autoreload_q, en_q};
    end
  end

  assign timer_irq = flag_q & irq_en_q;

  // Register and RAM update; RAM has no reset value but shares the block so
  // that stores are dropped while reset is held low
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      leds         <= '0;
      count_q      <= '0;
      cmp_q        <= '0;
      en_q         <= 1'b0;
      autoreload_q <= 1'b0;
      irq_en_q     <= 1'b0;
      flag_q       <= 1'b0;
    end else begin
      if (we && ram_hit) mem[idx] <= wdata;
      if (we && led_hit) leds <= wdata[LED_WIDTH-1:0];

      // CPU write beats increment or reload
      if (we && count_hit)      count_q <= wdata;
      else if (match && autoreload_q) count_q <= '0;
      else if (en_q)            count_q <= count_q + 32'd1;

      // Match above used the old compare value
      if (we && cmp_hit) cmp_q <= wdata;

      // New EN takes effect from the next edge
      if (we && ctrl_hit) begin
        en_q         <= wdata[0];
        autoreload_q <= wdata[1];
        irq_en_q     <= wdata[2];
      end

      // Hardware set beats write-1-clear
      if (match)                      flag_q <= 1'b1;
      else if (we && ctrl_hit && wdata[3]) flag_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_data_mem_mmio.sv
// Directed bench for data_mem_mmio: RAM, LED, timer and reset behaviour.
module tb_data_mem_mmio;

  logic        clk;
  logic        reset;
  logic        mem_write;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [7:0]  leds;
  logic        timer_irq;
  logic        misaligned;

  int vectors;
  int miscompares;

  data_mem_mmio #(.DEPTH_WORDS(64), .LED_WIDTH(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .mem_write (mem_write),
    .addr      (addr),
    .wdata     (wdata),
    .rdata     (rdata),
    .leds      (leds),
    .timer_irq (timer_irq),
    .misaligned(misaligned)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Store: drive on the falling edge, capture on the next rising edge
  task automatic store(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    addr = a; wdata = d; mem_write = 1'b1;
    @(posedge clk);
    #1;
    mem_write = 1'b0;
  endtask

  // Read: present address on the falling edge and settle
  task automatic set_read(input logic [31:0] a);
    @(negedge clk);
    addr = a; mem_write = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; mem_write = 1'b0; addr = '0; wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (leds !== 8'h00) begin miscompares++; $display("FAIL reset_leds got %h want 00", leds); end
    vectors++;
    if (timer_irq !== 1'b0) begin miscompares++; $display("FAIL reset_irq got %b want 0", timer_irq); end
    @(negedge clk);
    reset = 1'b1;
    set_read(32'h1004);
    vectors++;
    if (rdata !== 32'h0) begin miscompares++; $display("FAIL reset_tcount got %h want 0", rdata); end
    set_read(32'h1008);
    vectors++;
    if (rdata !== 32'h0) begin miscompares++; $display("FAIL reset_tcmp got %h want 0", rdata); end
    set_read(32'h100C);
    vectors++;
    if (rdata !== 32'h0) begin miscompares++; $display("FAIL reset_tctrl got %h want 0", rdata); end
    set_read(32'h0000_0001);
    vectors++;
    if (misaligned !== 1'b1 || rdata !== 32'h0) begin
      miscompares++; $display("FAIL misaligned_read got mis=%b rdata=%h want 1/0", misaligned, rdata);
    end
  endtask

  task automatic test_ram();
    store(32'h14, 32'h0);
    store(32'h10, 32'hDEAD_BEEF);
    set_read(32'h10);
    vectors++;
    if (rdata !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL ram_10 got %h want deadbeef", rdata); end
    vectors++;
    if (misaligned !== 1'b0) begin miscompares++; $display("FAIL aligned_flag got %b want 0", misaligned); end
    set_read(32'h14);
    vectors++;
    if (rdata !== 32'h0) begin miscompares++; $display("FAIL ram_14 got %h want 0", rdata); end
    // Misaligned store must not touch word 0x10
    store(32'h13, 32'h5555_5555);
    set_read(32'h10);
    vectors++;
    if (rdata !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL ram_misaligned_store got %h want deadbeef", rdata); end
    // Highest RAM word
    store(32'hFC, 32'hCAFE_F00D);
    set_read(32'hFC);
    vectors++;
    if (rdata !== 32'hCAFE_F00D) begin miscompares++; $display("FAIL ram_top got %h want cafef00d", rdata); end
  endtask

  task automatic test_led();
    store(32'h1000, 32'hFFFF_FFFF);
    vectors++;
    if (leds !== 8'hFF) begin miscompares++; $display("FAIL led_all got %h want ff", leds); end
    set_read(32'h1000);
    vectors++;
    if (rdata !== 32'h0000_00FF) begin miscompares++; $display("FAIL led_readback got %h want 000000ff", rdata); end
    store(32'h1000, 32'h0000_00A5);
    vectors++;
    if (leds !== 8'hA5) begin miscompares++; $display("FAIL led_a5 got %h want a5", leds); end
    @(negedge clk);
    addr = 32'h1002; wdata = 32'h3C; mem_write = 1'b1;
    #1;
    vectors++;
    if (misaligned !== 1'b1 || rdata !== 32'h0) begin
      miscompares++; $display("FAIL led_misaligned got mis=%b rdata=%h want 1/0", misaligned, rdata);
    end
    @(posedge clk);
    #1;
    mem_write = 1'b0;
    vectors++;
    if (leds !== 8'hA5) begin miscompares++; $display("FAIL led_misaligned_hold got %h want a5", leds); end
  endtask

  task automatic test_unmapped();
    store(32'h0, 32'h1111_1111);
    store(32'h2000, 32'hFFFF_FFFF);
    set_read(32'h2000);
    vectors++;
    if (rdata !== 32'h0) begin miscompares++; $display("FAIL unmapped_read got %h want 0", rdata); end
    set_read(32'h0);
    vectors++;
    if (rdata !== 32'h1111_1111) begin miscompares++; $display("FAIL unmapped_alias got %h want 11111111", rdata); end
    set_read(32'h1010);
    vectors++;
    if (rdata !== 32'h0) begin miscompares++; $display("FAIL unmapped_1010 got %h want 0", rdata); end
  endtask

  task automatic test_timer_match();
    store(32'h1008, 32'd3);
    store(32'h1004, 32'd0);
    store(32'h100C, 32'h5);
    for (int i = 0; i < 4; i++) begin
      set_read(32'h1004);
      vectors++;
      if (rdata !== 32'(i) || timer_irq !== 1'b0) begin
        miscompares++; $display("FAIL timer_count%0d got %0d irq=%b want %0d irq=0", i, rdata, timer_irq, i);
      end
    end
    set_read(32'h1004);
    vectors++;
    if (rdata !== 32'd4 || timer_irq !== 1'b1) begin
      miscompares++; $display("FAIL timer_flag got %0d irq=%b want 4 irq=1", rdata, timer_irq);
    end
    set_read(32'h100C);
    vectors++;
    if (rdata !== 32'hD) begin miscompares++; $display("FAIL timer_tctrl got %h want d", rdata); end
    store(32'h100C, 32'h8);
    set_read(32'h100C);
    vectors++;
    if (rdata !== 32'h0 || timer_irq !== 1'b0) begin
      miscompares++; $display("FAIL timer_clear got %h irq=%b want 0 irq=0", rdata, timer_irq);
    end
  endtask

  task automatic test_autoreload();
    logic [31:0] seq [6];
    seq[0] = 32'd0; seq[1] = 32'd1; seq[2] = 32'd2;
    seq[3] = 32'd0; seq[4] = 32'd1; seq[5] = 32'd2;
    store(32'h1004, 32'd0);
    store(32'h1008, 32'd2);
    store(32'h100C, 32'h3);
    for (int i = 0; i < 6; i++) begin
      set_read(32'h1004);
      vectors++;
      if (rdata !== seq[i]) begin
        miscompares++; $display("FAIL reload_seq%0d got %0d want %0d", i, rdata, seq[i]);
      end
    end
    // Clear and disable on the same edge as a match
    addr = 32'h100C; wdata = 32'h8; mem_write = 1'b1;
    @(posedge clk);
    #1;
    mem_write = 1'b0;
    set_read(32'h100C);
    vectors++;
    if (rdata !== 32'h8) begin miscompares++; $display("FAIL flag_set_beats_clear got %h want 8", rdata); end
    set_read(32'h1004);
    vectors++;
    if (rdata !== 32'd0) begin miscompares++; $display("FAIL reload_on_collision got %0d want 0", rdata); end
    set_read(32'h1004);
    vectors++;
    if (rdata !== 32'd0) begin miscompares++; $display("FAIL disabled_hold got %0d want 0", rdata); end
    store(32'h100C, 32'h8);
    set_read(32'h100C);
    vectors++;
    if (rdata !== 32'h0) begin miscompares++; $display("FAIL flag_clear got %h want 0", rdata); end
  endtask

  task automatic test_count_write_and_reset();
    store(32'h1008, 32'd102);
    store(32'h100C, 32'h5);
    store(32'h1004, 32'd100);
    set_read(32'h1004);
    vectors++;
    if (rdata !== 32'd100) begin miscompares++; $display("FAIL count_write got %0d want 100", rdata); end
    set_read(32'h1004);
    vectors++;
    if (rdata !== 32'd101) begin miscompares++; $display("FAIL count_after_write got %0d want 101", rdata); end
    set_read(32'h1004);
    vectors++;
    if (rdata !== 32'd102 || timer_irq !== 1'b0) begin
      miscompares++; $display("FAIL count_102 got %0d irq=%b want 102 irq=0", rdata, timer_irq);
    end
    set_read(32'h1004);
    vectors++;
    if (rdata !== 32'd103 || timer_irq !== 1'b1) begin
      miscompares++; $display("FAIL count_103 got %0d irq=%b want 103 irq=1", rdata, timer_irq);
    end
    // Asynchronous reset mid-cycle
    #2;
    reset = 1'b0;
    #1;
    vectors++;
    if (rdata !== 32'h0 || leds !== 8'h00 || timer_irq !== 1'b0) begin
      miscompares++; $display("FAIL async_reset got count=%h leds=%h irq=%b want 0/00/0", rdata, leds, timer_irq);
    end
    addr = 32'h1003;
    #1;
    vectors++;
    if (misaligned !== 1'b1) begin miscompares++; $display("FAIL reset_misaligned got %b want 1", misaligned); end
    // Stores are dropped while reset is low
    addr = 32'h10; wdata = 32'h1234_5678; mem_write = 1'b1;
    @(posedge clk);
    #1;
    mem_write = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    set_read(32'h10);
    vectors++;
    if (rdata !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL store_in_reset got %h want deadbeef", rdata); end
    set_read(32'h100C);
    vectors++;
    if (rdata !== 32'h0) begin miscompares++; $display("FAIL tctrl_after_reset got %h want 0", rdata); end
  endtask

  task automatic test_back_to_back();
    store(32'h20, 32'h0102_0304);
    store(32'h24, 32'hA0B0_C0D0);
    set_read(32'h20);
    vectors++;
    if (rdata !== 32'h0102_0304) begin miscompares++; $display("FAIL b2b_20 got %h want 01020304", rdata); end
    set_read(32'h24);
    vectors++;
    if (rdata !== 32'hA0B0_C0D0) begin miscompares++; $display("FAIL b2b_24 got %h want a0b0c0d0", rdata); end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_ram();
    test_led();
    test_unmapped();
    test_timer_match();
    test_autoreload();
    test_count_write_and_reset();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
